pfd_sync: RTL and testbench
===========================

PFD_SYNC -- requirements
Module: pfd_sync

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth for ref_in/fb_in.
REQ-002 SHALL provide parameter CNT_W, default 8, width of pulse-width counter.
REQ-003 SHALL provide parameter MAX_WIDTH, default 255, longest allowed UP/DOWN pulse in clk cycles (slip timeout).
REQ-004 clk  input  1  single block clock, rising-edge, oversamples ref_in/fb_in.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  detector enable; low forces idle.
REQ-007 ref_in  input  1  reference clock, asynchronous to clk.
REQ-008 fb_in  input  1  DCO feedback (divided) clock, asynchronous to clk.
REQ-009 p_up  output  1  active-low UP pulse to controller; high when idle.
REQ-010 p_down  output  1  active-low DOWN pulse to controller; high when idle.
REQ-011 pulse_width  output  CNT_W  cycle count of the last completed pulse.
REQ-012 width_valid  output  1  one-cycle strobe when pulse_width updates.
REQ-013 slip  output  1  one-cycle strobe on cycle slip or timeout.

Function
REQ-014 Rising edges SHALL be detected after SYNC_STAGES flops plus one edge register; ref_in high first sampled at clk edge k drives p_up low after edge k+3 (default depth).
REQ-015 FSM states SHALL be IDLE, LEAD_REF, LEAD_FB, COINC, RELEASE.
REQ-016 IDLE, ref edge only -> LEAD_REF (p_up=0, counter=1); fb edge only -> LEAD_FB (p_down=0, counter=1); both in same cycle -> COINC.
REQ-017 COINC SHALL drive p_up=0 and p_down=0 for exactly one cycle, then RELEASE; pulse_width=0, width_valid=1.
REQ-018 LEAD_REF on fb edge -> RELEASE, pulse_width=counter, width_valid=1; LEAD_FB symmetric on ref edge.
REQ-019 LEAD_REF on second ref edge (no fb) SHALL strobe slip, restart counter at 1, remain LEAD_REF; LEAD_FB symmetric.
REQ-020 counter reaching MAX_WIDTH SHALL force RELEASE with slip=1, pulse_width=MAX_WIDTH, width_valid=1; counter SHALL never wrap.
REQ-021 RELEASE SHALL hold p_up=p_down=1 for exactly one cycle, then IDLE, guaranteeing a rising edge of (p_up AND p_down) per pulse.
REQ-022 Edges detected during RELEASE or COINC SHALL set pending flags, consumed in the following IDLE cycle as if detected then; pending cleared on consumption.
REQ-023 p_up and p_down SHALL both be low only in COINC.
REQ-024 en low SHALL force IDLE within one cycle, outputs high, pending cleared, no strobes; synchronizers keep running.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 reset_n low SHALL asynchronously set: state=IDLE, p_up=1, p_down=1, pulse_width=0, width_valid=0, slip=0, counter=0, pending=0, synchronizer flops=0.
REQ-027 Reset mid-pulse SHALL abort the pulse with no width_valid or slip strobe; after deassertion an input already high SHALL NOT produce a false edge.

Structure
REQ-028 Package pll_pkg SHALL hold the FSM state enum, CNT_W and MAX_WIDTH defaults, shared with the controller.
REQ-029 One sub-module edge_sync (SYNC_STAGES flops + rise detect) SHALL be instantiated twice, for ref_in and fb_in.

Verification
REQ-030 ref_in rises 10 clk before fb_in -> p_up low 10 cycles, p_down high, pulse_width=10, width_valid one cycle, then one RELEASE cycle.
REQ-031 fb_in rises 4 clk before ref_in -> p_down low 4 cycles, pulse_width=4, p_up stays high.
REQ-032 ref_in and fb_in rise same clk -> both low exactly 1 cycle, pulse_width=0, slip=0.
REQ-033 ref_in toggles, fb_in held low -> slip strobe each extra ref edge, pulse ends at MAX_WIDTH=255 with slip=1, pulse_width=255.
REQ-034 fb edge lands in RELEASE cycle -> processed next IDLE cycle, p_down low with counter starting at 1, no edge lost.
REQ-035 reset_n low during LEAD_REF at count 5 -> p_up high immediately (asynchronous), no strobes; en low mid-pulse -> outputs high next cycle, no strobes.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL phase/frequency detector and its controller.
//   pfd_state_t   : detector FSM state encoding
//   CNT_W_DEF     : default pulse-width counter width
//   MAX_WIDTH_DEF : default longest UP/DOWN pulse in clk cycles (slip timeout)
package pll_pkg;

  localparam int CNT_W_DEF     = 8;
  localparam int MAX_WIDTH_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_REF,
    LEAD_FB,
    COINC,
    RELEASE
  } pfd_state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous clock-like input into clk and produces a
// registered one-cycle strobe on each rising edge.
//   clk     : sampling clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   rise    : one-cycle registered rising-edge strobe
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  // Rise detection stays blocked until the chain and the edge register hold
  // real post-reset samples, so an input already high at reset release is
  // not mistaken for an edge.
  localparam int WARM   = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [WARM_W-1:0]      warm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      warm_q <= WARM_W'(WARM);
      rise   <= 1'b0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= (warm_q == '0) && sync_q[SYNC_STAGES-1] && !prev_q;
      if (warm_q != '0) begin
        warm_q <= warm_q - WARM_W'(1);
      end
    end
  end

endmodule

// File: rtl/pfd_sync.sv
// Oversampled phase/frequency detector. Compares synchronized rising edges of
// ref_in and fb_in and emits active-low UP/DOWN pulses whose length is the
// phase error in clk cycles.
//   clk         : block clock, oversamples ref_in/fb_in
//   reset_n     : asynchronous active-low reset
//   en          : detector enable, low forces idle
//   ref_in      : reference clock (asynchronous)
//   fb_in       : divided DCO feedback clock (asynchronous)
//   p_up        : active-low UP pulse (ref leads)
//   p_down      : active-low DOWN pulse (fb leads)
//   pulse_width : length in cycles of the last completed pulse
//   width_valid : one-cycle strobe when pulse_width updates
//   slip        : one-cycle strobe on cycle slip or timeout
//
// state    | meaning
// IDLE     | waiting for a ref or fb edge (consumes pending edges)
// LEAD_REF | ref edge seen, p_up low, counting until fb edge
// LEAD_FB  | fb edge seen, p_down low, counting until ref edge
// COINC    | both edges in the same cycle, both outputs low one cycle
// RELEASE  | both outputs high one cycle, edges seen here are held pending
module pfd_sync
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MAX_WIDTH   = MAX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic             p_up,
  output logic             p_down,
  output logic [CNT_W-1:0] pulse_width,
  output logic             width_valid,
  output logic             slip
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic ref_rise, fb_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ref_in),
    .rise    (ref_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (fb_in),
    .rise    (fb_rise)
  );

  pfd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_ref_q, pend_ref_d;
  logic             pend_fb_q, pend_fb_d;
  logic             p_up_d, p_down_d;
  logic [CNT_W-1:0] width_d;
  logic             wv_d, slip_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_ref_q  <= 1'b0;
      pend_fb_q   <= 1'b0;
      p_up        <= 1'b1;
      p_down      <= 1'b1;
      pulse_width <= '0;
      width_valid <= 1'b0;
      slip        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_ref_q  <= pend_ref_d;
      pend_fb_q   <= pend_fb_d;
      p_up        <= p_up_d;
      p_down      <= p_down_d;
      pulse_width <= width_d;
      width_valid <= wv_d;
      slip        <= slip_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_ref_d = pend_ref_q;
    pend_fb_d  = pend_fb_q;
    width_d    = pulse_width;
    wv_d       = 1'b0;
    slip_d     = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      pend_ref_d = 1'b0;
      pend_fb_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pend_ref_d = 1'b0;
          pend_fb_d  = 1'b0;
          if ((ref_rise || pend_ref_q) && (fb_rise || pend_fb_q)) begin
            state_d = COINC;
          end else if (ref_rise || pend_ref_q) begin
            state_d = LEAD_REF;
            cnt_d   = ONE;
          end else if (fb_rise || pend_fb_q) begin
            state_d = LEAD_FB;
            cnt_d   = ONE;
          end
        end
        LEAD_REF: begin
          if (fb_rise) begin
            state_d    = RELEASE;
            width_d    = cnt_q;
            wv_d       = 1'b1;
            cnt_d      = '0;
            // a ref edge arriving with the closing fb edge starts the next
            // comparison instead of being dropped
            pend_ref_d = ref_rise;
          end else if (ref_rise) begin
            slip_d = 1'b1;
            cnt_d  = ONE;
          end else if (cnt_q >= MAX_CNT) begin
            state_d = RELEASE;
            width_d = MAX_CNT;
            wv_d    = 1'b1;
            slip_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        LEAD_FB: begin
          if (ref_rise) begin
            state_d   = RELEASE;
            width_d   = cnt_q;
            wv_d      = 1'b1;
            cnt_d     = '0;
            pend_fb_d = fb_rise;
          end else if (fb_rise) begin
            slip_d = 1'b1;
            cnt_d  = ONE;
          end else if (cnt_q >= MAX_CNT) begin
            state_d = RELEASE;
            width_d = MAX_CNT;
            wv_d    = 1'b1;
            slip_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        COINC: begin
          state_d    = RELEASE;
          width_d    = '0;
          wv_d       = 1'b1;
          pend_ref_d = pend_ref_q | ref_rise;
          pend_fb_d  = pend_fb_q | fb_rise;
        end
        RELEASE: begin
          state_d    = IDLE;
          pend_ref_d = pend_ref_q | ref_rise;
          pend_fb_d  = pend_fb_q | fb_rise;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // outputs follow the next state so they come straight off flops
    p_up_d   = !((state_d == LEAD_REF) || (state_d == COINC));
    p_down_d = !((state_d == LEAD_FB) || (state_d == COINC));
  end

endmodule

// File: tb/tb_pfd_sync.sv
module tb_pfd_sync;

  localparam int MAXW = 255;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       ref_in;
  logic       fb_in;
  logic       p_up;
  logic       p_down;
  logic [7:0] pulse_width;
  logic       width_valid;
  logic       slip;

  pfd_sync dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .ref_in      (ref_in),
    .fb_in       (fb_in),
    .p_up        (p_up),
    .p_down      (p_down),
    .pulse_width (pulse_width),
    .width_valid (width_valid),
    .slip        (slip)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: an edge counts when a sampled input goes 0->1, and it
  // acts on the outputs three clk edges after the first high sample. After
  // reset an edge needs four genuine samples behind it.
  bit hr[5];
  bit hf[5];
  int age;
  bit up_on, dn_on, gap, pr, pf;
  int len;
  int e_width;
  bit e_wv, e_slip;

  // observed activity since the last clr_obs
  int up_low, dn_low, both_low, wv_cnt, slip_cnt, last_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      hr[i] = 1'b0;
      hf[i] = 1'b0;
    end
    age = 0; up_on = 0; dn_on = 0; gap = 0; pr = 0; pf = 0; len = 0;
    e_width = 0; e_wv = 0; e_slip = 0;
  endtask

  task automatic model_step(input bit evr, input bit evf, input bit en_s);
    bit r, f;
    e_wv   = 0;
    e_slip = 0;
    if (!en_s) begin
      up_on = 0; dn_on = 0; gap = 0; pr = 0; pf = 0; len = 0;
    end else if (up_on && dn_on) begin
      up_on = 0; dn_on = 0; gap = 1; e_wv = 1; e_width = 0;
      pr = evr; pf = evf;
    end else if (gap) begin
      gap = 0; pr = pr | evr; pf = pf | evf;
    end else if (up_on) begin
      if (evf) begin
        e_width = len; e_wv = 1; up_on = 0; gap = 1; pr = evr;
      end else if (evr) begin
        e_slip = 1; len = 1;
      end else if (len == MAXW) begin
        e_width = MAXW; e_wv = 1; e_slip = 1; up_on = 0; gap = 1;
      end else begin
        len++;
      end
    end else if (dn_on) begin
      if (evr) begin
        e_width = len; e_wv = 1; dn_on = 0; gap = 1; pf = evf;
      end else if (evf) begin
        e_slip = 1; len = 1;
      end else if (len == MAXW) begin
        e_width = MAXW; e_wv = 1; e_slip = 1; dn_on = 0; gap = 1;
      end else begin
        len++;
      end
    end else begin
      r = evr | pr;
      f = evf | pf;
      pr = 0; pf = 0;
      if (r && f) begin
        up_on = 1; dn_on = 1;
      end else if (r) begin
        up_on = 1; len = 1;
      end else if (f) begin
        dn_on = 1; len = 1;
      end
    end
  endtask

  task automatic clr_obs();
    up_low = 0; dn_low = 0; both_low = 0; wv_cnt = 0; slip_cnt = 0; last_w = -1;
  endtask

  // one clk cycle: model update on the rising edge, compare on the falling edge
  task automatic tick();
    bit evr, evf;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int i = 4; i > 0; i--) begin
        hr[i] = hr[i-1];
        hf[i] = hf[i-1];
      end
      hr[0] = ref_in;
      hf[0] = fb_in;
      age++;
      evr = (age >= 5) && hr[3] && !hr[4];
      evf = (age >= 5) && hf[3] && !hf[4];
      model_step(evr, evf, en);
    end
    @(negedge clk);
    chk("p_up", p_up, !up_on);
    chk("p_down", p_down, !dn_on);
    chk("width_valid", width_valid, e_wv);
    chk("slip", slip, e_slip);
    chk("pulse_width", pulse_width, e_width);
    if (!p_up) up_low++;
    if (!p_down) dn_low++;
    if (!p_up && !p_down) both_low++;
    if (width_valid) begin
      wv_cnt++;
      last_w = pulse_width;
    end
    if (slip) slip_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int r_left, f_left, en_low;

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    ref_in  = 1'b0;
    fb_in   = 1'b0;
    model_reset();
    clr_obs();

    // reset state
    ticks(3);
    chk("rst_p_up", p_up, 1);
    chk("rst_p_down", p_down, 1);
    chk("rst_width", pulse_width, 0);
    chk("rst_wv", width_valid, 0);
    chk("rst_slip", slip, 0);
    reset_n = 1'b1;
    ticks(8);

    // ref leads fb by 10 cycles
    clr_obs();
    ref_in = 1'b1; ticks(10);
    fb_in  = 1'b1; ticks(8);
    ref_in = 1'b0; fb_in = 1'b0; ticks(6);
    chk("lead10_up_low", up_low, 10);
    chk("lead10_dn_low", dn_low, 0);
    chk("lead10_wv_cnt", wv_cnt, 1);
    chk("lead10_width", last_w, 10);
    chk("lead10_slip", slip_cnt, 0);

    // fb leads ref by 4 cycles
    clr_obs();
    fb_in  = 1'b1; ticks(4);
    ref_in = 1'b1; ticks(8);
    ref_in = 1'b0; fb_in = 1'b0; ticks(6);
    chk("lag4_dn_low", dn_low, 4);
    chk("lag4_up_low", up_low, 0);
    chk("lag4_width", last_w, 4);

    // coincident edges
    clr_obs();
    ref_in = 1'b1; fb_in = 1'b1; ticks(8);
    ref_in = 1'b0; fb_in = 1'b0; ticks(6);
    chk("coinc_both_low", both_low, 1);
    chk("coinc_up_low", up_low, 1);
    chk("coinc_width", last_w, 0);
    chk("coinc_wv_cnt", wv_cnt, 1);
    chk("coinc_slip", slip_cnt, 0);

    // ref toggles three times with fb held low, then the pulse times out
    clr_obs();
    for (int k = 0; k < 3; k++) begin
      ref_in = 1'b1; ticks(3);
      ref_in = 1'b0; ticks(3);
    end
    ticks(260);
    chk("slip_cnt", slip_cnt, 3);
    chk("slip_up_low", up_low, 267);
    chk("slip_width", last_w, MAXW);
    chk("slip_wv_cnt", wv_cnt, 1);
    ticks(4);

    // second fb edge lands in the RELEASE cycle and is held pending
    clr_obs();
    fb_in = 1'b1; ticks(3);
    fb_in = 1'b0; ticks(2);
    ref_in = 1'b1; tick();
    fb_in = 1'b1; tick();
    ref_in = 1'b0; ticks(6);
    ref_in = 1'b1; ticks(10);
    ref_in = 1'b0; fb_in = 1'b0; ticks(6);
    chk("pend_wv_cnt", wv_cnt, 2);
    chk("pend_dn_low", dn_low, 11);
    chk("pend_width", last_w, 6);
    chk("pend_slip", slip_cnt, 0);

    // reset during LEAD_REF at count 5, input left high across reset
    clr_obs();
    ref_in = 1'b1; ticks(4);
    chk("pre_rst_p_up", p_up, 0);
    ticks(4);
    reset_n = 1'b0;
    #1;
    chk("async_rst_p_up", p_up, 1);
    chk("async_rst_wv", width_valid, 0);
    chk("async_rst_slip", slip, 0);
    ticks(2);
    clr_obs();
    reset_n = 1'b1;
    ticks(20);
    chk("post_rst_up_low", up_low, 0);
    chk("post_rst_wv", wv_cnt, 0);
    chk("post_rst_slip", slip_cnt, 0);

    // en dropped mid-pulse
    ref_in = 1'b0; ticks(6);
    ref_in = 1'b1; ticks(6);
    chk("pre_en_p_up", p_up, 0);
    clr_obs();
    en = 1'b0; tick();
    chk("en_off_p_up", p_up, 1);
    ticks(5);
    en = 1'b1; ref_in = 1'b0; ticks(10);
    chk("en_off_wv", wv_cnt, 0);
    chk("en_off_slip", slip_cnt, 0);
    chk("en_off_up_low", up_low, 0);

    // randomized square waves on both inputs with occasional enable drops
    r_left = 5; f_left = 9; en_low = 0;
    for (int c = 0; c < 4000; c++) begin
      if (en_low > 0) begin
        en_low = en_low - 1;
        if (en_low == 0) en = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        en = 1'b0;
        en_low = $urandom_range(1, 5);
      end
      r_left = r_left - 1;
      if (r_left == 0) begin
        ref_in = !ref_in;
        r_left = $urandom_range(2, 40);
      end
      f_left = f_left - 1;
      if (f_left == 0) begin
        fb_in = !fb_in;
        f_left = $urandom_range(2, 40);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
